// File: rtl/setting_editor_pkg.sv
// Shared definitions for the settings page: state codes, field limits and a
// saturating step helper used by the settings editor and the game controller.
package setting_editor_pkg;

  localparam logic [2:0] ST_TITLE    = 3'd0;
  localparam logic [2:0] ST_PLAYER   = 3'd1;
  localparam logic [2:0] ST_QUESTION = 3'd2;
  localparam logic [2:0] ST_ATIME    = 3'd3;
  localparam logic [2:0] ST_WIN      = 3'd4;
  localparam logic [2:0] ST_SUCCESS  = 3'd5;
  localparam logic [2:0] ST_FAIL     = 3'd6;

  localparam logic [7:0] PLAYER_MIN   = 8'd1;  localparam logic [7:0] PLAYER_MAX   = 8'd4;
  localparam logic [7:0] PLAYER_DEF   = 8'd2;
  localparam logic [7:0] QUESTION_MIN = 8'd1;  localparam logic [7:0] QUESTION_MAX = 8'd9;
  localparam logic [7:0] QUESTION_DEF = 8'd5;
  localparam logic [7:0] ATIME_MIN    = 8'd5;  localparam logic [7:0] ATIME_MAX    = 8'd99;
  localparam logic [7:0] ATIME_DEF    = 8'd30;
  localparam logic [7:0] WIN_MIN      = 8'd1;  localparam logic [7:0] WIN_MAX      = 8'd99;
  localparam logic [7:0] WIN_DEF      = 8'd10;
  localparam logic [7:0] SUCCESS_MIN  = 8'd1;  localparam logic [7:0] SUCCESS_MAX  = 8'd9;
  localparam logic [7:0] SUCCESS_DEF  = 8'd1;
  localparam logic [7:0] FAIL_MIN     = 8'd0;  localparam logic [7:0] FAIL_MAX     = 8'd9;
  localparam logic [7:0] FAIL_DEF     = 8'd1;

  // Fields are at most 7 bits, so 8-bit math keeps 99+1 from wrapping before the clamp.
  function automatic logic [7:0] sat_step(input logic [7:0] v, input logic inc,
                                          input logic dec, input logic [7:0] lo,
                                          input logic [7:0] hi);
    logic [7:0] r;
    r = v;
    if (inc && !dec)      r = (v + 8'd1 > hi) ? hi : v + 8'd1;
    else if (dec && !inc) r = (v <= lo) ? lo : v - 8'd1;
    return r;
  endfunction

endpackage

// File: rtl/setting_editor_btn_debounce.sv
// One push-button front end: 2-flop sync, debounce, rising-edge pulse and
// optional auto-repeat while held.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000,
  parameter bit REPEAT_EN       = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn,
  input  logic i_hold,
  output logic o_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW = $clog2(RMAX + 1);

  logic [1:0]    r_sync;
  logic [DW-1:0] r_cnt;
  logic          r_lvl, r_lvl_d, r_held, r_rph;
  logic [RW-1:0] r_rcnt;
  logic          w_press, w_rep;

  assign w_press = r_lvl & ~r_lvl_d;
  assign w_rep   = REPEAT_EN && r_held && r_lvl && !i_hold &&
                   (r_rph ? (r_rcnt == RW'(REPEAT_PERIOD - 1))
                          : (r_rcnt == RW'(REPEAT_DELAY - 1)));
  assign o_pulse = w_press | w_rep;

  // Accepted level resets to "pressed" so a button held through reset must be
  // released and pressed again before it produces an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= 2'b00;
      r_cnt   <= '0;
      r_lvl   <= 1'b1;
      r_lvl_d <= 1'b1;
      r_held  <= 1'b0;
      r_rph   <= 1'b0;
      r_rcnt  <= '0;
    end else begin
      r_sync  <= {r_sync[0], i_btn};
      r_lvl_d <= r_lvl;
      if (r_sync[1] != r_lvl) begin
        if (r_cnt == DW'(DEBOUNCE_CYCLES - 1)) begin
          r_lvl <= r_sync[1];
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + DW'(1);
        end
      end else begin
        r_cnt <= '0;
      end

      if (w_press) begin
        r_held <= !i_hold;
        r_rph  <= 1'b0;
        r_rcnt <= '0;
      end else if (!r_lvl) begin
        r_held <= 1'b0;
        r_rph  <= 1'b0;
        r_rcnt <= '0;
      end else if (i_hold) begin
        r_rph  <= 1'b0;
        r_rcnt <= '0;
      end else if (r_held) begin
        if (w_rep) begin
          r_rph  <= 1'b1;
          r_rcnt <= '0;
        end else begin
          r_rcnt <= r_rcnt + RW'(1);
        end
      end
    end
  end

endmodule

// File: rtl/setting_editor.sv
// Settings page editor: owns the game settings registers, edits them from the
// push-buttons while view==0 and pulses settings_done on commit.
module setting_editor
  import setting_editor_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int REPEAT_DELAY    = 50_000_000,
  parameter int REPEAT_PERIOD   = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] view,
  input  logic       btn_next,
  input  logic       btn_prev,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_confirm,
  output logic [2:0] state,
  output logic [2:0] player_count,
  output logic [3:0] question_count,
  output logic [6:0] answer_time,
  output logic [6:0] win_socre,
  output logic [3:0] success_score,
  output logic [3:0] fail_score,
  output logic       settings_done
);

  logic [4:0] w_raw, w_pulse, w_p;
  logic       w_act, w_c, w_n, w_pv, w_u, w_d;
  logic [2:0] r_state, r_player;
  logic [3:0] r_question, r_success, r_fail;
  logic [6:0] r_atime, r_win;
  logic       r_done;

  // Bit order: 4 confirm, 3 next, 2 prev, 1 up, 0 down.
  assign w_raw = {btn_confirm, btn_next, btn_prev, btn_up, btn_down};
  assign w_act = (view == 3'd0);

  for (genvar i = 0; i < 5; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_DELAY   (REPEAT_DELAY),
      .REPEAT_PERIOD  (REPEAT_PERIOD),
      .REPEAT_EN      (i < 2)
    ) u_btn (
      .clk    (clk),
      .rst    (rst),
      .i_btn  (w_raw[i]),
      .i_hold (!w_act),
      .o_pulse(w_pulse[i])
    );
  end

  assign w_p  = w_pulse & {5{w_act}};
  assign w_c  = w_p[4];
  assign w_n  = w_p[3];
  assign w_pv = w_p[2];
  assign w_u  = w_p[1];
  assign w_d  = w_p[0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_TITLE;
      r_done     <= 1'b0;
      r_player   <= 3'(PLAYER_DEF);
      r_question <= 4'(QUESTION_DEF);
      r_atime    <= 7'(ATIME_DEF);
      r_win      <= 7'(WIN_DEF);
      r_success  <= 4'(SUCCESS_DEF);
      r_fail     <= 4'(FAIL_DEF);
    end else begin
      r_done <= 1'b0;
      if (w_c) begin
        if (r_state == ST_TITLE) begin
          r_state <= ST_PLAYER;
        end else begin
          r_state <= ST_TITLE;
          r_done  <= 1'b1;
        end
      end else if (r_state != ST_TITLE) begin
        if (w_n) begin
          r_state <= (r_state == ST_FAIL) ? ST_PLAYER : r_state + 3'd1;
        end else if (w_pv) begin
          r_state <= (r_state == ST_PLAYER) ? ST_FAIL : r_state - 3'd1;
        end else if (w_u || w_d) begin
          case (r_state)
            ST_PLAYER:   r_player   <= 3'(sat_step(8'(r_player), w_u, w_d, PLAYER_MIN, PLAYER_MAX));
            ST_QUESTION: r_question <= 4'(sat_step(8'(r_question), w_u, w_d, QUESTION_MIN, QUESTION_MAX));
            ST_ATIME:    r_atime    <= 7'(sat_step(8'(r_atime), w_u, w_d, ATIME_MIN, ATIME_MAX));
            ST_WIN:      r_win      <= 7'(sat_step(8'(r_win), w_u, w_d, WIN_MIN, WIN_MAX));
            ST_SUCCESS:  r_success  <= 4'(sat_step(8'(r_success), w_u, w_d, SUCCESS_MIN, SUCCESS_MAX));
            ST_FAIL:     r_fail     <= 4'(sat_step(8'(r_fail), w_u, w_d, FAIL_MIN, FAIL_MAX));
            default: ;
          endcase
        end
      end
    end
  end

  assign state          = r_state;
  assign player_count   = r_player;
  assign question_count = r_question;
  assign answer_time    = r_atime;
  assign win_socre      = r_win;
  assign success_score  = r_success;
  assign fail_score     = r_fail;
  assign settings_done  = r_done;

endmodule
